seven_seg_scan_driver: RTL

//  Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits sharing one segment bus.

---
 rtl/seven_seg_scan_driver.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexed driver for NUM_DIGITS seven-segment digits sharing one
// segment bus. A shadow copy of value/dp/digit_en is captured on load, one
// digit is scanned per slot of SCAN_DIV clocks, and the first cycle of every
// slot is blanked so the previous digit never ghosts onto the next one.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seven_seg_scan_driver #(
    parameter  int NUM_DIGITS     = 4,
    parameter  int SCAN_DIV       = 50000,
    parameter  int SEG_ACTIVE_LOW = 1,
    parameter  int AN_ACTIVE_LOW  = 1,
    localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int PRE_W          = $clog2(SCAN_DIV)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [NUM_DIGITS-1:0]   en_q;
    logic [PRE_W-1:0]        presc;
    logic [NUM_DIGITS-1:0]   lz_mask;

    logic [3:0]              nibble;
    logic                    dp_sel;
    logic                    en_sel;
    logic                    lz_sel;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [6:0]              seg_low;
    logic                    dp_lit;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    wrap;

    // Hex nibble to active-low {g,f,e,d,c,b,a} pattern
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Shadow registers decouple the display from the datapath between loads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            dp_q    <= '0;
            en_q    <= '0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp;
            en_q    <= digit_en;
        end
    end

    assign wrap = (presc == PRE_LAST);

    // Slot prescaler and digit index; the index advances when a slot ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            digit_idx <= '0;
        end else if (wrap) begin
            presc     <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            presc     <= presc + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i>0 is a leading zero when it and every higher nibble are zero
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (value_q[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Select the shadow fields belonging to the digit in the current slot
    always_comb begin
        nibble = 4'h0;
        dp_sel = 1'b0;
        en_sel = 1'b0;
        lz_sel = 1'b0;
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                nibble    = value_q[4*i +: 4];
                dp_sel    = dp_q[i];
                en_sel    = en_q[i];
                lz_sel    = lz_mask[i];
                onehot[i] = 1'b1;
            end
        end
    end

    // Build next outputs; slot cycle 0 and disabled digits stay dark
    always_comb begin
        seg_low = 7'h7F;
        dp_lit  = 1'b0;
        an_sel  = '0;
        if ((presc != '0) && en_sel) begin
            dp_lit = dp_sel;
            if (!lz_sel) begin
                an_sel  = onehot;
                seg_low = decode(nibble);
            end
        end
        seg_next = (SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low;
        dp_next  = (SEG_ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
        an_next  = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
    end

    // Register pin outputs; frame_done marks the first cycle of a new frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp_out     <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp_out     <= dp_next;
            an         <= an_next;
            frame_done <= wrap && (digit_idx == IDX_LAST);
        end
    end

endmodule
